// File: rtl/instr_buff_resp.sv
// Instruction-buffer responder: queues fetch requests and serves them in order,
// one 32-bit memory read at a time, returning data plus the original tag.
module instr_buff_resp #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_buff_rd_en,
    input  logic [31:0]      i_buff_addr,
    input  logic [38:0]      i_buff_tag,
    output logic             o_buff_ack,
    output logic [31:0]      o_buff_instr,
    output logic [38:0]      o_buff_tag_out,
    output logic             o_mem_rd_en,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [31:0]      i_mem_rd_data,
    output logic [CNT_W-1:0] o_req_count,
    output logic             o_busy,
    output logic             o_req_overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_q_addr [DEPTH];
    logic [38:0]      r_q_tag  [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_addr, r_instr;
    logic [38:0]      r_tag_out;
    logic             r_ovf;
    logic             w_full, w_pop, w_push, w_capture;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = (r_state == S_RESP);
    // A pop in the same cycle frees the head slot, so a push at full still fits.
    assign w_push    = i_buff_rd_en && (!w_full || w_pop);
    assign w_capture = (r_state == S_ISSUE || r_state == S_WAIT) && i_mem_ack;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
            S_ISSUE: w_next = i_mem_ack ? S_RESP : S_WAIT;
            S_WAIT:  if (i_mem_ack) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= i_buff_addr;
            r_q_tag[r_wr_ptr]  <= i_buff_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_instr    <= '0;
            r_tag_out  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (i_buff_rd_en && w_full && !w_pop) r_ovf <= 1'b1;
            if (r_state == S_IDLE && w_next == S_ISSUE) r_mem_addr <= r_q_addr[r_rd_ptr];
            // Head is stable until RESP pops it, so tag is latched with the data.
            if (w_capture) begin
                r_instr   <= i_mem_rd_data;
                r_tag_out <= r_q_tag[r_rd_ptr];
            end
        end
    end

    assign o_buff_ack     = (r_state == S_RESP);
    assign o_buff_instr   = r_instr;
    assign o_buff_tag_out = r_tag_out;
    assign o_mem_rd_en    = (r_state == S_ISSUE);
    assign o_mem_addr     = r_mem_addr;
    assign o_req_count    = r_count;
    assign o_busy         = (r_state != S_IDLE) || (r_count != '0);
    assign o_req_overflow = r_ovf;
endmodule

// File: doc/instr_buff_resp.md
# instr_buff_resp

Instruction-buffer responder on the far end of the fetch unit's buffer request interface. Accepts `buff_rd_en`/`buff_addr`/`buff_tag` requests, queues them, and performs one 32-bit read per request on a simple memory port. Returns the instruction word and the original tag with a one-cycle `buff_ack` to the fetch scheduler and wavepool. Sits between the compute unit's fetch stage and the instruction memory / L1-I port.

## Interface
Parameters:
- `DEPTH`, 4: request queue entries; power of two, ≥2.
- `CNT_W`, 3: width of `req_count`; equals log2(`DEPTH`)+1.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `buff_rd_en`  in  1  fetch request strobe; one request per cycle high.
- `buff_addr`  in  32  instruction byte address.
- `buff_tag`  in  39  opaque tag; bit 38 = half flag, [37:32] = wfid, [31:0] = pc.
- `buff_ack`  out  1  one-cycle pulse; `buff_instr`/`buff_tag_out` valid this cycle.
- `buff_instr`  out  32  fetched instruction word.
- `buff_tag_out`  out  39  tag of the completed request, unmodified.
- `mem_rd_en`  out  1  one-cycle memory read strobe.
- `mem_addr`  out  32  read address; equals queued `buff_addr`.
- `mem_ack`  in  1  memory read complete; `mem_rd_data` valid.
- `mem_rd_data`  in  32  read data.
- `req_count`  out  CNT_W  number of queued requests, including the one in flight.
- `busy`  out  1  FSM not in IDLE or queue non-empty.
- `req_overflow`  out  1  sticky: a request arrived with the queue full and was dropped.

## Operation
- Queue: circular FIFO of {addr, tag}, `DEPTH` entries, wr/rd pointers wrap modulo `DEPTH`. Push on `buff_rd_en`. Pop on the RESP state.
- Push while full and no pop in the same cycle: the request is dropped and `req_overflow` is set. The flag clears only on `rst`.
- Push and pop in the same cycle while full: the push is accepted and `req_count` is unchanged.
- Fetch never stalls on this block. The scheduler's in-flight limit guarantees ≤`DEPTH` outstanding requests, and overflow is an error indication only.
- FSM states:
  - IDLE: if queue non-empty → ISSUE, else stay.
  - ISSUE: `mem_rd_en`=1, `mem_addr` = head addr, for exactly one cycle. If `mem_ack` is also high this cycle → RESP and capture data; else → WAIT.
  - WAIT: hold until `mem_ack`. On `mem_ack`, capture `mem_rd_data` → RESP. No timeout.
  - RESP: `buff_ack`=1, `buff_instr` = captured data, `buff_tag_out` = head tag, pop head → IDLE.
- `mem_ack` in IDLE or RESP is ignored; this covers stale responses after reset.
- Requests complete strictly in order, one outstanding memory read at a time.
- `mem_addr` holds its last value outside ISSUE. `buff_instr`/`buff_tag_out` hold their last values outside RESP.

## Timing
- Reset values: every output is 0. FSM = IDLE, pointers = 0.
- Reset asserted mid-operation drops the queue and the in-flight read immediately. No `buff_ack` is generated for dropped requests.
- Request sampled at the edge ending cycle 0:
  - queue non-empty in cycle 1;
  - ISSUE in cycle 2 (`mem_rd_en` high);
  - with `mem_ack` in cycle 2, RESP in cycle 3 (`buff_ack`).
- Minimum latency from `buff_rd_en` to `buff_ack` is 3 cycles. Memory latency of L cycles after `mem_rd_en` gives 3+L cycles.
- Throughput: minimum 3 cycles per request (IDLE, ISSUE, RESP). The next ISSUE begins the cycle after RESP returns to IDLE.
- `req_count` updates on the edge following push/pop.
- `busy` is combinational from state and count.

## Test plan
- Single request: `buff_rd_en` cycle 0, addr 0x100, tag 0x05_0000_0100, memory acks same cycle as `mem_rd_en` with 0xBF810000 → `mem_rd_en` cycle 2 with `mem_addr`=0x100. Cycle 3: `buff_ack`=1, `buff_instr`=0xBF810000, `buff_tag_out`=0x05_0000_0100.
- Slow memory: `mem_ack` 5 cycles after `mem_rd_en` → exactly one `mem_rd_en` pulse, `buff_ack` 1 cycle after `mem_ack`. A spurious `mem_ack` in IDLE produces no `buff_ack`.
- Ordering and wrap: 6 requests, tags 0..5, issued across two bursts so pointers wrap at `DEPTH`=4 → six `buff_ack` pulses with tags 0..5 in order, data matching each address.
- Full queue: 5 back-to-back requests with memory stalled → `req_count` saturates at 4 and `req_overflow`=1. The 5th tag never returns, and the first four complete.
- Simultaneous push/pop at full: push arrives in the RESP cycle with count 4 → accepted, `req_count` stays 4, `req_overflow` stays 0.
- Reset mid-flight: assert `rst` during WAIT with 3 queued → all outputs 0 immediately. A post-reset `mem_ack` is ignored, and a new request completes normally with 3-cycle latency.
